// File: rtl/tricklock_pkg.sv
// Shared types and constants for the TrickLock password-entry stage.
package tricklock_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        OPEN  = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;

endpackage

// File: rtl/pw_entry_ctrl_lockout_timer.sv
// Loadable down-counter that holds at zero; times the alarm lockout.
module lockout_timer #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pw_entry_ctrl.sv
// Password-entry FSM: 4-digit shift buffer, code compare, wrong-attempt
// counter and timed alarm lockout. All outputs are registered.
module pw_entry_ctrl
    import tricklock_pkg::*;
#(
    parameter logic [15:0]  DEFAULT_CODE = 16'h1234,
    parameter int unsigned  MAX_ERR      = 3,
    parameter int unsigned  LOCK_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_val,
    input  logic       enter,
    input  logic       clr_in,
    input  logic       lock,
    output logic [3:0] pw0,
    output logic [3:0] pw1,
    output logic [3:0] pw2,
    output logic [3:0] pw3,
    output logic       clear,
    output logic       unlock,
    output logic       alarm,
    output logic [3:0] err_cnt,
    output logic [2:0] digit_cnt
);

    localparam int unsigned TW = $clog2(LOCK_CYCLES);

    state_t      state, state_n;
    logic [15:0] code, code_n;
    logic [3:0]  pw0_n, pw1_n, pw2_n, pw3_n;
    logic [3:0]  err_cnt_n;
    logic [2:0]  digit_cnt_n;
    logic        clear_n, unlock_n, alarm_n;
    logic        tmr_load;
    logic [TW-1:0] tmr_count;
    logic        tmr_expired;
    logic        buf_full;
    logic        code_match;

    lockout_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TW'(LOCK_CYCLES - 1)),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    assign buf_full   = (digit_cnt == 3'(NUM_DIGITS));
    assign code_match = ({pw3, pw2, pw1, pw0} == code);

    // State register plus the datapath registers that move with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ENTRY;
            code      <= DEFAULT_CODE;
            pw0       <= '0;
            pw1       <= '0;
            pw2       <= '0;
            pw3       <= '0;
            err_cnt   <= '0;
            digit_cnt <= '0;
            clear     <= 1'b1;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            code      <= code_n;
            pw0       <= pw0_n;
            pw1       <= pw1_n;
            pw2       <= pw2_n;
            pw3       <= pw3_n;
            err_cnt   <= err_cnt_n;
            digit_cnt <= digit_cnt_n;
            clear     <= clear_n;
            unlock    <= unlock_n;
            alarm     <= alarm_n;
        end
    end

    // Strobes form a priority chain: a taken branch drops every lower strobe,
    // even when the taken branch itself has no effect in the current state.
    always_comb begin
        state_n     = state;
        code_n      = code;
        pw0_n       = pw0;
        pw1_n       = pw1;
        pw2_n       = pw2;
        pw3_n       = pw3;
        err_cnt_n   = err_cnt;
        digit_cnt_n = digit_cnt;
        tmr_load    = 1'b0;

        if (state == ALARM) begin
            if (tmr_expired && tmr_count == '0) begin
                state_n   = ENTRY;
                err_cnt_n = '0;
            end
        end else if (clr_in) begin
            {pw3_n, pw2_n, pw1_n, pw0_n} = '0;
            digit_cnt_n = '0;
        end else if (enter) begin
            if (buf_full) begin
                {pw3_n, pw2_n, pw1_n, pw0_n} = '0;
                digit_cnt_n = '0;
                if (state == OPEN) begin
                    code_n  = {pw3, pw2, pw1, pw0};
                    state_n = ENTRY;
                end else if (code_match) begin
                    state_n   = OPEN;
                    err_cnt_n = '0;
                end else if (err_cnt + 4'd1 >= 4'(MAX_ERR)) begin
                    state_n   = ALARM;
                    err_cnt_n = 4'(MAX_ERR);
                    tmr_load  = 1'b1;
                end else begin
                    err_cnt_n = err_cnt + 4'd1;
                end
            end
        end else if (lock) begin
            if (state == OPEN) begin
                {pw3_n, pw2_n, pw1_n, pw0_n} = '0;
                digit_cnt_n = '0;
                state_n     = ENTRY;
            end
        end else if (key_valid && !buf_full) begin
            pw3_n       = pw2;
            pw2_n       = pw1;
            pw1_n       = pw0;
            pw0_n       = key_val;
            digit_cnt_n = digit_cnt + 3'd1;
        end
    end

    always_comb begin
        clear_n  = (digit_cnt_n == '0) || (state_n == ALARM);
        unlock_n = (state_n == OPEN);
        alarm_n  = (state_n == ALARM);
    end

endmodule

// File: tb/tb_pw_entry_ctrl.sv
// Directed self-checking bench for pw_entry_ctrl (MAX_ERR=3, LOCK_CYCLES=8).
module tb_pw_entry_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_val = '0;
    logic       enter = 1'b0;
    logic       clr_in = 1'b0;
    logic       lock = 1'b0;
    logic [3:0] pw0, pw1, pw2, pw3;
    logic       clear, unlock, alarm;
    logic [3:0] err_cnt;
    logic [2:0] digit_cnt;

    int tests  = 0;
    int failed = 0;

    pw_entry_ctrl #(
        .DEFAULT_CODE (16'h1234),
        .MAX_ERR      (3),
        .LOCK_CYCLES  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_val   (key_val),
        .enter     (enter),
        .clr_in    (clr_in),
        .lock      (lock),
        .pw0       (pw0),
        .pw1       (pw1),
        .pw2       (pw2),
        .pw3       (pw3),
        .clear     (clear),
        .unlock    (unlock),
        .alarm     (alarm),
        .err_cnt   (err_cnt),
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        key_valid = 1'b0;
        enter     = 1'b0;
        clr_in    = 1'b0;
        lock      = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        key_valid = 1'b1;
        key_val   = v;
        tick();
    endtask

    task automatic submit();
        enter = 1'b1;
        tick();
    endtask

    task automatic code4(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    initial begin
        // reset state
        reset = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_pw",     {16'h0, pw3, pw2, pw1, pw0}, 32'h0);
        chk("rst_digits", digit_cnt, 0);
        chk("rst_err",    err_cnt, 0);
        chk("rst_clear",  clear, 1);
        chk("rst_unlock", unlock, 0);
        chk("rst_alarm",  alarm, 0);

        // correct default code
        press(4'h1);
        chk("k1_clear", clear, 0);
        chk("k1_pw0",   pw0, 4'h1);
        chk("k1_digits", digit_cnt, 1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        chk("k4_buf",    {16'h0, pw3, pw2, pw1, pw0}, 32'h1234);
        chk("k4_digits", digit_cnt, 4);
        submit();
        chk("open_unlock", unlock, 1);
        chk("open_digits", digit_cnt, 0);
        chk("open_clear",  clear, 1);
        chk("open_pw0",    pw0, 0);
        lock = 1'b1;
        tick();
        chk("lock_unlock", unlock, 0);

        // three wrong codes -> alarm for exactly 8 cycles
        code4(16'h5555);
        submit();
        chk("wrong1_err", err_cnt, 1);
        chk("wrong1_alarm", alarm, 0);
        code4(16'h5555);
        submit();
        chk("wrong2_err", err_cnt, 2);
        code4(16'h5555);
        submit();
        chk("wrong3_err",   err_cnt, 3);
        chk("wrong3_alarm", alarm, 1);
        chk("wrong3_clear", clear, 1);
        for (int i = 0; i < 7; i++) begin
            key_valid = 1'b1;
            key_val   = 4'h9;
            enter     = (i == 3);
            tick();
            chk("alarm_hold",   alarm, 1);
            chk("alarm_digits", digit_cnt, 0);
        end
        tick();
        chk("alarm_end",     alarm, 0);
        chk("alarm_end_err", err_cnt, 0);
        chk("alarm_end_clear", clear, 1);

        // code change in OPEN
        code4(16'h1234);
        submit();
        chk("reopen_unlock", unlock, 1);
        code4(16'h9876);
        submit();
        chk("chg_unlock", unlock, 0);
        code4(16'h1234);
        submit();
        chk("old_code_err",    err_cnt, 1);
        chk("old_code_unlock", unlock, 0);
        code4(16'h9876);
        submit();
        chk("new_code_unlock", unlock, 1);
        chk("new_code_err",    err_cnt, 0);
        lock = 1'b1;
        tick();

        // fifth key ignored, short enter ignored
        code4(16'h1234);
        press(4'h7);
        chk("k5_pw0",    pw0, 4'h4);
        chk("k5_pw3",    pw3, 4'h1);
        chk("k5_digits", digit_cnt, 4);
        clr_in = 1'b1;
        tick();
        chk("clr_digits", digit_cnt, 0);
        chk("clr_clear",  clear, 1);
        press(4'h1);
        press(4'h2);
        press(4'h3);
        submit();
        chk("short_digits", digit_cnt, 3);
        chk("short_err",    err_cnt, 0);
        chk("short_unlock", unlock, 0);
        clr_in = 1'b1;
        tick();

        // clr_in beats enter and key_valid
        code4(16'h9876);
        clr_in = 1'b1;
        enter  = 1'b1;
        tick();
        chk("clr_enter_digits", digit_cnt, 0);
        chk("clr_enter_unlock", unlock, 0);
        chk("clr_enter_err",    err_cnt, 0);
        press(4'h5);
        chk("pre_clrkey_digits", digit_cnt, 1);
        clr_in    = 1'b1;
        key_valid = 1'b1;
        key_val   = 4'h7;
        tick();
        chk("clr_key_digits", digit_cnt, 0);
        chk("clr_key_pw0",    pw0, 0);

        // reset during alarm restores default code
        for (int n = 0; n < 3; n++) begin
            code4(16'h5555);
            submit();
        end
        chk("alarm2_on", alarm, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_alarm_alarm", alarm, 0);
        chk("rst_alarm_err",   err_cnt, 0);
        chk("rst_alarm_clear", clear, 1);
        code4(16'h1234);
        submit();
        chk("rst_code_unlock", unlock, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
